// File: rtl/priority_resolver_isr.sv
// Priority resolver / in-service register stage after the IRR: picks the winning request, runs INTA, holds ISR.
// Optional SPECIAL_MASK_MODE_EN adds the smm input, which lifts fully-nested blocking.
module priority_resolver_isr #(
  parameter logic [2:0] RESET_LOWEST   = 3'd7,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] irrBits,
  input  logic [7:0] imr,
  input  logic       intaN,
  input  logic [4:0] icw2Base,
  input  logic       autoEoi,
  input  logic       eoiCmd,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       rotateOnEoi,
  input  logic       readPriorityAck,
`ifdef SPECIAL_MASK_MODE_EN
  input  logic       smm,
`endif
  output logic       intOut,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] vectorOut,
  output logic       vectorValid,
  output logic [7:0] isrOut,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_CLR   = 3'd2;
  localparam logic [2:0] S_ACKW  = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_VEC   = 3'd5;

  logic [2:0] r_state;
  logic [7:0] r_isr;
  logic [2:0] r_lowest;
  logic       r_ack_seen;
  logic       r_inta_prev;
  logic [2:0] r_level;
  logic       r_spurious;
  logic [2:0] r_reset_irr;
  logic [7:0] r_vector;
  logic       r_vector_valid;
  logic       r_pend;

  logic       w_fall;
  logic       w_rise;
  logic [7:0] w_elig;
  logic [2:0] w_scan_idx;
  logic       w_win_found;
  logic [2:0] w_win_lvl;
  logic [2:0] w_win_rank;
  logic       w_isr_found;
  logic [2:0] w_isr_top;
  logic [2:0] w_isr_rank;
  logic       w_nest_ok;
  logic       w_winner;
  logic [2:0] w_eoi_lvl;
  logic [7:0] w_isr_next;
  logic [2:0] w_lowest_next;

  assign w_fall = r_inta_prev & ~intaN;
  assign w_rise = ~r_inta_prev & intaN;
  assign w_elig = irrBits & ~imr & ~r_isr;

  // Scan from lowest rank upward so the last hit is the highest-priority level.
  always_comb begin
    w_scan_idx  = '0;
    w_win_found = 1'b0;
    w_win_lvl   = '0;
    w_win_rank  = '0;
    w_isr_found = 1'b0;
    w_isr_top   = '0;
    w_isr_rank  = '0;
    for (int k = 7; k >= 0; k--) begin
      w_scan_idx = r_lowest + 3'd1 + 3'(k);
      if (w_elig[w_scan_idx]) begin
        w_win_found = 1'b1;
        w_win_lvl   = w_scan_idx;
        w_win_rank  = 3'(k);
      end
      if (r_isr[w_scan_idx]) begin
        w_isr_found = 1'b1;
        w_isr_top   = w_scan_idx;
        w_isr_rank  = 3'(k);
      end
    end
  end

`ifdef SPECIAL_MASK_MODE_EN
  assign w_nest_ok = smm | ~w_isr_found | (w_win_rank < w_isr_rank);
`else
  assign w_nest_ok = ~w_isr_found | (w_win_rank < w_isr_rank);
`endif
  assign w_winner = w_win_found & w_nest_ok;

  // EOI acts on the old ISR first, then the INTA set, then the auto-EOI clear.
  always_comb begin
    w_isr_next    = r_isr;
    w_lowest_next = r_lowest;
    w_eoi_lvl     = eoiSpecific ? eoiLevel : w_isr_top;
    if (eoiCmd && w_isr_found) begin
      w_isr_next[w_eoi_lvl] = 1'b0;
      if (rotateOnEoi) w_lowest_next = w_eoi_lvl;
    end
    if ((r_state == S_REQ) && w_fall && w_winner) w_isr_next[w_win_lvl] = 1'b1;
    if ((r_state == S_VEC) && w_rise && autoEoi && !r_spurious) begin
      w_isr_next[r_level] = 1'b0;
      if (rotateOnEoi) w_lowest_next = r_level;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_isr          <= '0;
      r_lowest       <= RESET_LOWEST;
      r_ack_seen     <= readPriorityAck;
      r_inta_prev    <= 1'b1;
      r_level        <= '0;
      r_spurious     <= 1'b0;
      r_reset_irr    <= '0;
      r_vector       <= '0;
      r_vector_valid <= 1'b0;
      r_pend         <= 1'b0;
    end else begin
      r_inta_prev <= intaN;
      r_isr       <= w_isr_next;
      r_lowest    <= w_lowest_next;
      case (r_state)
        S_IDLE: if (w_winner) r_state <= S_REQ;
        S_REQ: begin
          if (w_fall) begin
            r_pend <= 1'b0;
            if (w_winner) begin
              r_level     <= w_win_lvl;
              r_reset_irr <= w_win_lvl;
              r_spurious  <= 1'b0;
              r_state     <= S_CLR;
            end else begin
              r_level    <= SPURIOUS_LEVEL;
              r_spurious <= 1'b1;
              r_state    <= S_WAIT2;
            end
          end
        end
        S_CLR: begin
          if (w_fall) r_pend <= 1'b1;
          r_state <= S_ACKW;
        end
        S_ACKW: begin
          // An early second INTA is remembered until the IRR has acknowledged.
          if (w_fall) r_pend <= 1'b1;
          if (readPriorityAck != r_ack_seen) begin
            r_ack_seen <= readPriorityAck;
            r_state    <= S_WAIT2;
          end
        end
        S_WAIT2: begin
          if (w_fall || r_pend) begin
            r_vector       <= {icw2Base, r_level};
            r_vector_valid <= 1'b1;
            r_pend         <= 1'b0;
            r_state        <= S_VEC;
          end
        end
        S_VEC: begin
          if (w_rise) begin
            r_vector_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign intOut       = (r_state == S_REQ);
  assign readPriority = (r_state == S_CLR);
  assign resetIRR     = r_reset_irr;
  assign vectorOut    = r_vector;
  assign vectorValid  = r_vector_valid;
  assign isrOut       = r_isr;
  assign busy         = (r_state != S_IDLE);

endmodule
